ascon_perm_engine: RTL and testbench

//  Iterative ASCON permutation p^a with round count chosen per operation (a = 1..12; 12/8/6 in use).

---
 rtl/ascon_perm_engine_if.sv | 22 ++
 rtl/ascon_perm_engine.sv | 133 +++++++++++++
 tb/tb_ascon_perm_engine.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_engine_if.sv
// Request/result handshake bundle for the ASCON permutation engine.
// The master drives requests and consumes results; the slave is the engine.
interface ascon_perm_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] state_in;
  logic [3:0]   rounds_in;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, rounds_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, rounds_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/ascon_perm_engine.sv
// Iterative ASCON permutation p^a, UNROLL rounds per clock, valid/ready on both sides.
// The state register is loaded on accept, advanced in RUN, and held stable in HOLD.
module ascon_perm_engine #(
  parameter int UNROLL = 1
) (
  input logic               clk,
  input logic               rst_n,
  ascon_perm_engine_if.slave bus
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 4 && UNROLL != 6) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1, 2, 3, 4 or 6");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t       state_q, state_d;
  logic [319:0] s_q, s_d;
  logic [3:0]   a_q, a_d;
  logic [3:0]   i_q, i_d;
  logic [319:0] chain;
  logic [4:0]   rnd;
  logic [4:0]   nxt;

  // One full round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [3:0]  hi;
    {x0, x1, x2, x3, x4} = s;
    hi = 4'hF - idx;
    x2 = x2 ^ {56'b0, hi, idx};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  // State, round counter and round target registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      a_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      a_q     <= a_d;
      i_q     <= i_d;
    end
  end

  // Rounds past the target are skipped, so a short final cycle applies only the remainder.
  always_comb begin
    chain = s_q;
    rnd   = '0;
    for (int u = 0; u < UNROLL; u++) begin
      rnd = {1'b0, i_q} + 5'(u);
      if (rnd < {1'b0, a_q}) begin
        chain = ascon_round(chain, 4'd12 - a_q + rnd[3:0]);
      end
    end
    nxt = {1'b0, i_q} + 5'(UNROLL);
  end

  // Next-state and handshake outputs; a=0 passes through RUN for one cycle with no rounds.
  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    a_d           = a_q;
    i_d           = i_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          s_d     = bus.state_in;
          a_d     = (bus.rounds_in > 4'd12) ? 4'd12 : bus.rounds_in;
          i_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        s_d      = chain;
        if (nxt >= {1'b0, a_q}) begin
          i_d     = a_q;
          state_d = HOLD;
        end else begin
          i_d = nxt[3:0];
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.state_out = s_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Runs identical requests into UNROLL=1, 3 and 4 engines and checks results and
// latencies against a column-wise S-box-table model of the ASCON permutation.
module tb_ascon_perm_engine;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ascon_perm_engine_if bus1 ();
  ascon_perm_engine_if bus3 ();
  ascon_perm_engine_if bus4 ();

  ascon_perm_engine #(.UNROLL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ascon_perm_engine #(.UNROLL(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  ascon_perm_engine #(.UNROLL(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  localparam int UNR [3] = '{1, 3, 4};

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic [2:0]   ov, ir, bz;
  logic [319:0] so [3];

  assign ov    = {bus4.out_valid, bus3.out_valid, bus1.out_valid};
  assign ir    = {bus4.in_ready,  bus3.in_ready,  bus1.in_ready};
  assign bz    = {bus4.busy,      bus3.busy,      bus1.busy};
  assign so[0] = bus1.state_out;
  assign so[1] = bus3.state_out;
  assign so[2] = bus4.state_out;

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference permutation: round constant from the round index, S-box applied per bit column.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int a);
    logic [63:0] x [5];
    logic [4:0]  col;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    for (int r = 0; r < a; r++) begin
      int idx;
      idx  = 12 - a + r;
      x[2] = x[2] ^ 64'(((15 - idx) << 4) | idx);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        col = SBOX[col];
        x[0][b] = col[4];
        x[1][b] = col[3];
        x[2][b] = col[2];
        x[3][b] = col[1];
        x[4][b] = col[0];
      end
      x[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
      x[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
      x[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
      x[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
      x[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] v;
    for (int j = 0; j < 10; j++) v[j*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic drive_req(input logic v, input logic [319:0] s, input logic [3:0] r);
    bus1.in_valid = v; bus1.state_in = s; bus1.rounds_in = r;
    bus3.in_valid = v; bus3.state_in = s; bus3.rounds_in = r;
    bus4.in_valid = v; bus4.state_in = s; bus4.rounds_in = r;
  endtask

  task automatic set_ready(input logic r);
    bus1.out_ready = r;
    bus3.out_ready = r;
    bus4.out_ready = r;
  endtask

  // One request into all engines; rounds_in is scrambled right after accept.
  task automatic run_op(input logic [319:0] s, input logic [3:0] rin, input string name);
    logic [319:0] exp;
    logic [319:0] got [3];
    int           lat [3];
    bit           done [3];
    int           a;
    int           cyc;
    a   = (rin > 4'd12) ? 12 : int'(rin);
    exp = model_perm(s, a);
    @(negedge clk);
    drive_req(1'b1, s, rin);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL %s ready_before_accept u=%0d got=%b want=1", name, UNR[k], ir[k]);
      end
      done[k] = 1'b0;
      lat[k]  = 0;
      got[k]  = '0;
    end
    @(posedge clk); #1;
    drive_req(1'b0, rand_state(), 4'($urandom_range(0, 15)));
    cyc = 0;
    while (!(done[0] && done[1] && done[2]) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!done[k] && ov[k] === 1'b1) begin
          done[k] = 1'b1;
          lat[k]  = cyc;
          got[k]  = so[k];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      int el;
      el = (a == 0) ? 1 : (a + UNR[k] - 1) / UNR[k];
      total++;
      if (!done[k]) begin
        bad++;
        $display("[TB] FAIL %s timeout u=%0d a=%0d got=no_out_valid want=out_valid", name, UNR[k], a);
      end else begin
        if (got[k] !== exp) begin
          bad++;
          $display("[TB] FAIL %s state u=%0d a=%0d got=%h want=%h", name, UNR[k], a, got[k], exp);
        end
        total++;
        if (lat[k] != el) begin
          bad++;
          $display("[TB] FAIL %s latency u=%0d a=%0d got=%0d want=%0d", name, UNR[k], a, lat[k], el);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready u=%0d got=%b want=1", UNR[k], ir[k]); end
      total++;
      if (ov[k] !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid u=%0d got=%b want=0", UNR[k], ov[k]); end
      total++;
      if (bz[k] !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy u=%0d got=%b want=0", UNR[k], bz[k]); end
      total++;
      if (so[k] !== '0) begin bad++; $display("[TB] FAIL reset_state u=%0d got=%h want=0", UNR[k], so[k]); end
    end
  endtask

  task automatic test_single_round();
    logic [63:0] c;
    logic [63:0] want_x2;
    c       = 64'h4B;
    want_x2 = ~(c ^ ror64(c, 1) ^ ror64(c, 6));
    run_op('0, 4'd1, "single_round");
    total++;
    if (so[0][63:0] !== 64'h0) begin
      bad++;
      $display("[TB] FAIL single_round_x4 got=%h want=0", so[0][63:0]);
    end
    total++;
    if (so[0][191:128] !== want_x2) begin
      bad++;
      $display("[TB] FAIL single_round_x2 got=%h want=%h", so[0][191:128], want_x2);
    end
  endtask

  task automatic test_random_rounds();
    logic [3:0] std_a [3];
    std_a = '{4'd12, 4'd8, 4'd6};
    for (int j = 0; j < 3; j++) begin
      for (int n = 0; n < 3; n++) run_op(rand_state(), std_a[j], "std_rounds");
    end
    for (int n = 0; n < 6; n++) run_op(rand_state(), 4'($urandom_range(1, 12)), "rand_rounds");
  endtask

  task automatic test_bypass_clamp();
    run_op(rand_state(), 4'd0, "bypass");
    run_op(rand_state(), 4'd13, "clamp13");
    run_op(rand_state(), 4'd14, "clamp14");
    run_op(rand_state(), 4'd15, "clamp15");
  endtask

  // Consumer stalls in HOLD while a competing request is offered each cycle.
  task automatic test_hold_stall();
    logic [319:0] s;
    logic [319:0] exp;
    int           cyc;
    s   = rand_state();
    exp = model_perm(s, 8);
    set_ready(1'b0);
    @(negedge clk);
    drive_req(1'b1, s, 4'd8);
    @(posedge clk); #1;
    drive_req(1'b0, '0, 4'd0);
    cyc = 0;
    while (ov !== 3'b111 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (ov !== 3'b111) begin
      bad++;
      $display("[TB] FAIL stall_reach_hold got=%b want=111", ov);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_req(1'b1, rand_state(), 4'd5);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ov[k] !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid u=%0d got=%b want=1", UNR[k], ov[k]); end
        total++;
        if (ir[k] !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready u=%0d got=%b want=0", UNR[k], ir[k]); end
        total++;
        if (so[k] !== exp) begin bad++; $display("[TB] FAIL stall_state u=%0d got=%h want=%h", UNR[k], so[k], exp); end
      end
      drive_req(1'b0, '0, 4'd0);
    end
    @(negedge clk);
    set_ready(1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL release_idle u=%0d got=ready%b_valid%b want=ready1_valid0", UNR[k], ir[k], ov[k]);
      end
      total++;
      if (so[k] !== exp) begin bad++; $display("[TB] FAIL release_state u=%0d got=%h want=%h", UNR[k], so[k], exp); end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    drive_req(1'b1, rand_state(), 4'd12);
    @(posedge clk); #1;
    drive_req(1'b0, '0, 4'd0);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bz[0] !== 1'b1) begin bad++; $display("[TB] FAIL midrun_busy got=%b want=1", bz[0]); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || bz[k] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midrun_reset_flags u=%0d got=r%b_v%b_b%b want=r1_v0_b0", UNR[k], ir[k], ov[k], bz[k]);
      end
      total++;
      if (so[k] !== '0) begin bad++; $display("[TB] FAIL midrun_reset_state u=%0d got=%h want=0", UNR[k], so[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(rand_state(), 4'd12, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    set_ready(1'b1);
    drive_req(1'b0, '0, 4'd0);
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_single_round();
    test_random_rounds();
    test_bypass_clamp();
    test_hold_stall();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
